// File: rtl/uart_tx_arbiter.sv
// Arbitrates an echo-byte FIFO and a switch-status message onto a single UART transmitter.
// Define UART_TX_CRLF_EN to insert CR (8'h0D) before the trailing LF of the status message.
module uart_tx_arbiter #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       echo_push,
    input  logic [7:0] echo_data,
    output logic       echo_full,
    input  logic       msg_req,
    input  logic       sw_mode,
    input  logic       sw_sel_mode,
    input  logic       sw_sel_display,
    output logic       msg_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_done
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned IDX_W = 3;
`ifdef UART_TX_CRLF_EN
    localparam int unsigned MSG_LEN = 6;
`else
    localparam int unsigned MSG_LEN = 5;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, count_next;
    logic             echo_pend;
    logic             push_ok;
    logic             pop;

    logic             snap_mode, snap_sel_mode, snap_sel_display;
    logic             grant_msg, grant_msg_next;
    logic [IDX_W-1:0] msg_idx, idx_next;
    logic             rr_msg_last, rr_msg_next;
    logic             msg_done;
    logic [7:0]       data_next;

    // Status message byte at position idx, built from the switch snapshot
    function automatic logic [7:0] msg_byte(input logic [IDX_W-1:0] idx,
                                            input logic m, input logic s, input logic d);
        logic [7:0] b;
        case (idx)
            3'd0:    b = 8'h53;
            3'd1:    b = 8'h30 + {7'd0, m};
            3'd2:    b = 8'h30 + {7'd0, s};
            3'd3:    b = 8'h30 + {7'd0, d};
`ifdef UART_TX_CRLF_EN
            3'd4:    b = 8'h0D;
            3'd5:    b = 8'h0A;
`else
            3'd4:    b = 8'h0A;
`endif
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign echo_pend  = (count != '0);
    // A full FIFO still accepts a push when a pop frees a slot in the same cycle
    assign push_ok    = echo_push && ((count != CNT_W'(FIFO_DEPTH)) || pop);
    assign count_next = count + CNT_W'(push_ok) - CNT_W'(pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        grant_msg_next = grant_msg;
        data_next      = tx_data;
        idx_next       = msg_idx;
        rr_msg_next    = rr_msg_last;
        pop            = 1'b0;
        msg_done       = 1'b0;
        case (state)
            IDLE: begin
                // In IDLE a set msg_busy means the message has not started yet
                if (echo_pend && (!msg_busy || rr_msg_last)) begin
                    grant_msg_next = 1'b0;
                    data_next      = mem[rd_ptr];
                    pop            = 1'b1;
                    rr_msg_next    = 1'b0;
                    state_next     = START;
                end else if (msg_busy) begin
                    grant_msg_next = 1'b1;
                    data_next      = msg_byte(3'd0, snap_mode, snap_sel_mode, snap_sel_display);
                    idx_next       = 3'd1;
                    rr_msg_next    = 1'b1;
                    state_next     = START;
                end
            end
            START: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (tx_done) begin
                    if (grant_msg && (msg_idx < IDX_W'(MSG_LEN))) begin
                        data_next  = msg_byte(msg_idx, snap_mode, snap_sel_mode, snap_sel_display);
                        idx_next   = msg_idx + 3'd1;
                        state_next = START;
                    end else begin
                        msg_done   = grant_msg;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Transmit-side registers: start pulse, held byte, grant and message progress
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            grant_msg   <= 1'b0;
            msg_idx     <= '0;
            rr_msg_last <= 1'b1;
        end else begin
            tx_start    <= (state_next == START);
            tx_data     <= data_next;
            grant_msg   <= grant_msg_next;
            msg_idx     <= idx_next;
            rr_msg_last <= rr_msg_next;
        end
    end

    // Message request acceptance and switch snapshot
    always_ff @(posedge clk) begin
        if (rst) begin
            msg_busy         <= 1'b0;
            snap_mode        <= 1'b0;
            snap_sel_mode    <= 1'b0;
            snap_sel_display <= 1'b0;
        end else if (msg_done) begin
            msg_busy <= 1'b0;
        end else if (msg_req && !msg_busy) begin
            msg_busy         <= 1'b1;
            snap_mode        <= sw_mode;
            snap_sel_mode    <= sw_sel_mode;
            snap_sel_display <= sw_sel_display;
        end
    end

    // Echo FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            echo_full <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count     <= count_next;
            echo_full <= (count_next == CNT_W'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= echo_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: scoreboard of expected transmit bytes plus a
// table of switch patterns and hand-written arbitration, overflow and reset sequences.
module tb_uart_tx_arbiter;

    localparam int unsigned DEPTH    = 4;
    localparam int          DONE_LAT = 10;
`ifdef UART_TX_CRLF_EN
    localparam int          MSG_LEN  = 6;
`else
    localparam int          MSG_LEN  = 5;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       echo_push = 1'b0;
    logic [7:0] echo_data = 8'h00;
    logic       echo_full;
    logic       msg_req = 1'b0;
    logic       sw_mode = 1'b0;
    logic       sw_sel_mode = 1'b0;
    logic       sw_sel_display = 1'b0;
    logic       msg_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_done = 1'b0;

    uart_tx_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .echo_push      (echo_push),
        .echo_data      (echo_data),
        .echo_full      (echo_full),
        .msg_req        (msg_req),
        .sw_mode        (sw_mode),
        .sw_sel_mode    (sw_sel_mode),
        .sw_sel_display (sw_sel_display),
        .msg_busy       (msg_busy),
        .tx_start       (tx_start),
        .tx_data        (tx_data),
        .tx_done        (tx_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       m;
        logic       s;
        logic       d;
        logic [7:0] e1;
        logic [7:0] e2;
        logic [7:0] e3;
    } msg_vec_t;

    msg_vec_t   vecs [4];
    int         n_checks = 0;
    int         n_pass = 0;
    int         cyc = 0;
    int         starts = 0;
    int         last_done_cyc = -100;
    logic [7:0] exp_q [$];
    bit         hold = 1'b0;
    bit         pending = 1'b0;
    int         cd = 0;
    logic [7:0] cur_byte = 8'h00;
    logic       prev_start = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(posedge clk) cyc = cyc + 1;

    // Transmitter model: checks each started byte against the scoreboard, answers tx_done later
    always @(posedge clk) begin
        #1;
        tx_done = 1'b0;
        if (rst) begin
            pending = 1'b0;
        end else begin
            if (tx_start) begin
                starts++;
                check("tx_start_single_cycle", int'(prev_start), 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_tx_byte", int'(tx_data), 256);
                end else begin
                    cur_byte = exp_q.pop_front();
                    check("tx_byte", int'(tx_data), int'(cur_byte));
                end
                pending = 1'b1;
                cd      = DONE_LAT;
            end else if (pending && !hold) begin
                cd--;
                if (cd == 0) begin
                    check("tx_data_held", int'(tx_data), int'(cur_byte));
                    tx_done       = 1'b1;
                    pending       = 1'b0;
                    last_done_cyc = cyc;
                end
            end
        end
        prev_start = tx_start;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic push_echo(input logic [7:0] b, input bit expect_tx);
        echo_data = b;
        echo_push = 1'b1;
        if (expect_tx) exp_q.push_back(b);
        tick();
        echo_push = 1'b0;
    endtask

    task automatic queue_msg(input int i);
        exp_q.push_back(8'h53);
        exp_q.push_back(vecs[i].e1);
        exp_q.push_back(vecs[i].e2);
        exp_q.push_back(vecs[i].e3);
`ifdef UART_TX_CRLF_EN
        exp_q.push_back(8'h0D);
`endif
        exp_q.push_back(8'h0A);
    endtask

    task automatic send_msg(input int i);
        sw_mode        = vecs[i].m;
        sw_sel_mode    = vecs[i].s;
        sw_sel_display = vecs[i].d;
        msg_req        = 1'b1;
        queue_msg(i);
        tick();
        msg_req = 1'b0;
    endtask

    // Waits for msg_busy to fall and checks it fell exactly one cycle after the last tx_done
    task automatic wait_msg(input string name);
        bit done = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            tick();
            if (!msg_busy) begin
                done = 1'b1;
                break;
            end
        end
        check({name, "_busy_fall_seen"}, int'(done), 1);
        if (done) check({name, "_busy_fall_delay"}, cyc - last_done_cyc, 1);
    endtask

    task automatic wait_drain(input string name);
        bit done = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            tick();
            if (exp_q.size() == 0 && !pending) begin
                done = 1'b1;
                break;
            end
        end
        check({name, "_drained"}, int'(done), 1);
        repeat (4) tick();
    endtask

    initial begin
        int s0;
        int s1;
        vecs[0] = '{m: 1'b1, s: 1'b0, d: 1'b1, e1: 8'h31, e2: 8'h30, e3: 8'h31};
        vecs[1] = '{m: 1'b0, s: 1'b0, d: 1'b0, e1: 8'h30, e2: 8'h30, e3: 8'h30};
        vecs[2] = '{m: 1'b1, s: 1'b1, d: 1'b1, e1: 8'h31, e2: 8'h31, e3: 8'h31};
        vecs[3] = '{m: 1'b0, s: 1'b1, d: 1'b0, e1: 8'h30, e2: 8'h31, e3: 8'h30};

        do_reset();
        check("rst_tx_start", int'(tx_start), 0);
        check("rst_tx_data", int'(tx_data), 0);
        check("rst_msg_busy", int'(msg_busy), 0);
        check("rst_echo_full", int'(echo_full), 0);

        // Single echo byte
        s0 = starts;
        push_echo(8'h72, 1'b1);
        wait_drain("echo1");
        check("echo1_starts", starts - s0, 1);
        check("echo1_full", int'(echo_full), 0);
        repeat (20) tick();
        check("echo1_fifo_empty", starts - s0, 1);

        // Status messages for each switch pattern in the table
        for (int i = 0; i < 4; i++) begin
            s0 = starts;
            send_msg(i);
            check("msg_busy_set", int'(msg_busy), 1);
            wait_msg("msg");
            check("msg_starts", starts - s0, MSG_LEN);
            check("msg_bytes_left", exp_q.size(), 0);
        end

        // Echo pushes during a message wait until it completes
        s0 = starts;
        send_msg(0);
        tick();
        tick();
        push_echo(8'h61, 1'b1);
        msg_req = 1'b1;
        tick();
        msg_req = 1'b0;
        push_echo(8'h62, 1'b1);
        wait_msg("msg_echo");
        wait_drain("msg_echo");
        check("msg_echo_starts", starts - s0, MSG_LEN + 2);

        // Tie after reset: echo first, then message, then remaining echo
        do_reset();
        s0 = starts;
        sw_mode = 1'b1; sw_sel_mode = 1'b0; sw_sel_display = 1'b1;
        msg_req   = 1'b1;
        echo_data = 8'hA1;
        echo_push = 1'b1;
        exp_q.push_back(8'hA1);
        queue_msg(0);
        exp_q.push_back(8'hA2);
        tick();
        msg_req   = 1'b0;
        echo_data = 8'hA2;
        tick();
        echo_push = 1'b0;
        wait_drain("tie");
        check("tie_starts", starts - s0, MSG_LEN + 2);
        check("tie_busy", int'(msg_busy), 0);

        // Overflow: transmitter stalled, FIFO fills, extra pushes dropped
        hold = 1'b1;
        s0 = starts;
        push_echo(8'hB0, 1'b1);
        repeat (3) tick();
        for (int i = 0; i < int'(DEPTH) + 2; i++) push_echo(8'hC0 + 8'(i), i < int'(DEPTH));
        tick();
        check("ovf_full", int'(echo_full), 1);
        check("ovf_stalled_starts", starts - s0, 1);
        hold = 1'b0;
        wait_drain("ovf");
        check("ovf_starts", starts - s0, int'(DEPTH) + 1);
        check("ovf_full_clear", int'(echo_full), 0);

        // Reset during the third message byte abandons it
        s0 = starts;
        send_msg(2);
        for (int k = 0; k < 500 && (starts - s0) < 3; k++) tick();
        check("rst_mid_third_byte", starts - s0, 3);
        repeat (3) tick();
        rst = 1'b1;
        exp_q.delete();
        s1 = starts;
        tick();
        check("rst_mid_tx_start", int'(tx_start), 0);
        tick();
        rst = 1'b0;
        check("rst_mid_busy", int'(msg_busy), 0);
        check("rst_mid_full", int'(echo_full), 0);
        check("rst_mid_tx_data", int'(tx_data), 0);
        repeat (20) tick();
        check("rst_mid_no_start", starts - s1, 0);
        s0 = starts;
        send_msg(3);
        wait_msg("msg_after_rst");
        check("msg_after_rst_starts", starts - s0, MSG_LEN);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
